// File: rtl/seq_op_unit.sv
// Registered, handshaked unsigned operator unit. Single-cycle ops latch their result on accept;
// div/rem run a restoring divider that produces one quotient bit per cycle, MSB first.
module seq_op_unit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_err
);

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_e;

    typedef enum logic [4:0] {
        OP_ADD = 5'd0, OP_SUB, OP_MUL, OP_DIV, OP_REM, OP_EQ, OP_NE, OP_LT,
        OP_LE, OP_GT, OP_GE, OP_AND, OP_OR, OP_XOR, OP_XNOR, OP_SHR,
        OP_SHL, OP_SEL, OP_RAND, OP_ROR, OP_RXOR, OP_LNOT, OP_NEG
    } op_e;

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] res_q;
    logic             err_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] divisor_q;
    logic [CW-1:0]    cnt_q;
    logic             rem_sel_q;

    logic             accept;
    logic             div_start;
    logic [WIDTH-1:0] alu_res;
    logic             alu_err;
    logic [WIDTH:0]   part_d;
    logic [WIDTH:0]   diff_d;
    logic             ge_d;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;

    assign in_ready   = rst_n && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign accept     = in_valid && in_ready;
    assign div_start  = ((in_op == OP_DIV) || (in_op == OP_REM)) && (in_b != '0);
    assign out_valid  = (state_q == DONE);
    assign out_result = res_q;
    assign out_err    = err_q;

    // Div/rem entries here only cover the divide-by-zero case; b!=0 goes through the divider.
    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (in_op)
            OP_ADD:  alu_res = in_a + in_b;
            OP_SUB:  alu_res = in_a - in_b;
            OP_MUL:  alu_res = in_a * in_b;
            OP_DIV:  begin alu_res = '1;   alu_err = 1'b1; end
            OP_REM:  begin alu_res = in_a; alu_err = 1'b1; end
            OP_EQ:   alu_res = WIDTH'(in_a == in_b);
            OP_NE:   alu_res = WIDTH'(in_a != in_b);
            OP_LT:   alu_res = WIDTH'(in_a < in_b);
            OP_LE:   alu_res = WIDTH'(in_a <= in_b);
            OP_GT:   alu_res = WIDTH'(in_a > in_b);
            OP_GE:   alu_res = WIDTH'(in_a >= in_b);
            OP_AND:  alu_res = in_a & in_b;
            OP_OR:   alu_res = in_a | in_b;
            OP_XOR:  alu_res = in_a ^ in_b;
            OP_XNOR: alu_res = ~(in_a ^ in_b);
            OP_SHR:  alu_res = in_a >> in_b;
            OP_SHL:  alu_res = in_a << in_b;
            OP_SEL:  alu_res = (in_a != '0) ? in_b : in_c;
            OP_RAND: alu_res = WIDTH'(&in_a);
            OP_ROR:  alu_res = WIDTH'(|in_a);
            OP_RXOR: alu_res = WIDTH'(^in_a);
            OP_LNOT: alu_res = WIDTH'(in_a == '0);
            OP_NEG:  alu_res = '0 - in_a;
            default: alu_err = 1'b1;
        endcase
    end

    // Partial remainder stays below 2*divisor, so WIDTH+1 bits cover the trial subtraction.
    always_comb begin
        part_d = {rem_q, quo_q[WIDTH-1]};
        diff_d = part_d - {1'b0, divisor_q};
        ge_d   = (part_d >= {1'b0, divisor_q});
        rem_d  = ge_d ? diff_d[WIDTH-1:0] : part_d[WIDTH-1:0];
        quo_d  = (quo_q << 1) | WIDTH'(ge_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            res_q     <= '0;
            err_q     <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
            rem_sel_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        if (div_start) begin
                            quo_q     <= in_a;
                            rem_q     <= '0;
                            divisor_q <= in_b;
                            cnt_q     <= '0;
                            rem_sel_q <= (in_op == OP_REM);
                            state_q   <= DIV;
                        end else begin
                            res_q   <= alu_res;
                            err_q   <= alu_err;
                            state_q <= DONE;
                        end
                    end else if ((state_q == DONE) && out_ready) begin
                        state_q <= IDLE;
                    end
                end
                DIV: begin
                    quo_q <= quo_d;
                    rem_q <= rem_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST_STEP) begin
                        res_q   <= rem_sel_q ? rem_d : quo_d;
                        err_q   <= 1'b0;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_op_unit.sv
// Directed and randomized checks of seq_op_unit at WIDTH = 8, 3 and 1 against an arithmetic
// reference model of the operator set.
module tb_seq_op_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [4:0]  in_op;
    logic [63:0] a_s, b_s, c_s;
    logic        out_ready;
    logic [2:0]  vld;

    logic        rdy [3];
    logic        ov  [3];
    logic        er  [3];
    logic [7:0]  r8;
    logic [2:0]  r3;
    logic        r1;
    logic [63:0] res [3];

    assign res[0] = 64'(r8);
    assign res[1] = 64'(r3);
    assign res[2] = 64'(r1);

    int n_checks = 0;
    int n_fail   = 0;

    seq_op_unit #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[0]), .in_ready(rdy[0]), .in_op(in_op),
        .in_a(a_s[7:0]), .in_b(b_s[7:0]), .in_c(c_s[7:0]), .out_valid(ov[0]),
        .out_ready(out_ready), .out_result(r8), .out_err(er[0])
    );

    seq_op_unit #(.WIDTH(3)) u_w3 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[1]), .in_ready(rdy[1]), .in_op(in_op),
        .in_a(a_s[2:0]), .in_b(b_s[2:0]), .in_c(c_s[2:0]), .out_valid(ov[1]),
        .out_ready(out_ready), .out_result(r3), .out_err(er[1])
    );

    seq_op_unit #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[2]), .in_ready(rdy[2]), .in_op(in_op),
        .in_a(a_s[0:0]), .in_b(b_s[0:0]), .in_c(c_s[0:0]), .out_valid(ov[2]),
        .out_ready(out_ready), .out_result(r1), .out_err(er[2])
    );

    function automatic int wof(input int inst);
        case (inst)
            0:       return 8;
            1:       return 3;
            default: return 1;
        endcase
    endfunction

    function automatic logic [63:0] mask_of(input int w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] model(input int w, input int op, input logic [63:0] a,
                                          input logic [63:0] b, input logic [63:0] c,
                                          output logic err);
        logic [63:0] m;
        logic [63:0] r;
        m   = mask_of(w);
        err = 1'b0;
        r   = '0;
        case (op)
            0:  r = a + b;
            1:  r = a - b;
            2:  r = a * b;
            3:  if (b == 0) begin r = m; err = 1'b1; end else r = a / b;
            4:  if (b == 0) begin r = a; err = 1'b1; end else r = a % b;
            5:  r = 64'(a == b);
            6:  r = 64'(a != b);
            7:  r = 64'(a < b);
            8:  r = 64'(a <= b);
            9:  r = 64'(a > b);
            10: r = 64'(a >= b);
            11: r = a & b;
            12: r = a | b;
            13: r = a ^ b;
            14: r = ~(a ^ b);
            15: r = (b >= 64'(w)) ? 64'd0 : (a >> b);
            16: r = (b >= 64'(w)) ? 64'd0 : (a << b);
            17: r = (a != 0) ? b : c;
            18: r = 64'(a == m);
            19: r = 64'(a != 0);
            20: r = 64'($countones(a) % 2);
            21: r = 64'(a == 0);
            22: r = 64'd0 - a;
            default: begin r = 64'd0; err = 1'b1; end
        endcase
        return r & m;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input int inst, input int op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] c,
                          input logic [63:0] exp_res, input logic exp_err, input string tag);
        int w;
        int n;
        int lat;
        int exp_lat;
        w       = wof(inst);
        exp_lat = (((op == 3) || (op == 4)) && ((b & mask_of(w)) != 0)) ? w + 1 : 1;
        out_ready = 1'b1;
        n = 0;
        while (!rdy[inst] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, " in_ready"}, 64'(rdy[inst]), 64'd1);
        in_op = 5'(op);
        a_s = a;
        b_s = b;
        c_s = c;
        vld[inst] = 1'b1;
        @(negedge clk);
        vld[inst] = 1'b0;
        a_s   = {$urandom, $urandom};
        b_s   = {$urandom, $urandom};
        c_s   = {$urandom, $urandom};
        in_op = 5'($urandom);
        lat = 1;
        while (!ov[inst] && lat < 100) begin
            check({tag, " busy in_ready"}, 64'(rdy[inst]), 64'd0);
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " result"}, res[inst], exp_res);
        check({tag, " err"}, 64'(er[inst]), 64'(exp_err));
    endtask

    task automatic model_op(input int inst, input int op, input logic [63:0] a,
                            input logic [63:0] b, input logic [63:0] c);
        int w;
        logic [63:0] m;
        logic [63:0] exp;
        logic        e;
        w   = wof(inst);
        m   = mask_of(w);
        exp = model(w, op, a & m, b & m, c & m, e);
        run_op(inst, op, a & m, b & m, c & m, exp, e, $sformatf("w%0d op%0d", w, op));
    endtask

    initial begin
        rst_n = 1'b0;
        vld = '0;
        out_ready = 1'b0;
        in_op = '0;
        a_s = '0;
        b_s = '0;
        c_s = '0;

        repeat (2) @(negedge clk);
        check("reset out_valid", 64'(ov[0]), 64'd0);
        check("reset out_result", res[0], 64'd0);
        check("reset out_err", 64'(er[0]), 64'd0);
        check("reset in_ready", 64'(rdy[0]), 64'd0);
        rst_n = 1'b1;
        #1;
        check("idle in_ready", 64'(rdy[0]), 64'd1);

        // Streaming: a new op every cycle while out_ready is held high.
        begin
            logic [4:0]  s_op  [4];
            logic [63:0] s_a   [4];
            logic [63:0] s_b   [4];
            logic [63:0] s_exp [4];
            s_op[0] = 5'd0;  s_a[0] = 64'hF0; s_b[0] = 64'h20; s_exp[0] = 64'h10;
            s_op[1] = 5'd13; s_a[1] = 64'h3C; s_b[1] = 64'h0F; s_exp[1] = 64'h33;
            s_op[2] = 5'd7;  s_a[2] = 64'h05; s_b[2] = 64'h09; s_exp[2] = 64'h01;
            s_op[3] = 5'd12; s_a[3] = 64'h81; s_b[3] = 64'h18; s_exp[3] = 64'h99;
            @(negedge clk);
            out_ready = 1'b1;
            for (int i = 0; i < 4; i++) begin
                check($sformatf("stream%0d in_ready", i), 64'(rdy[0]), 64'd1);
                in_op = s_op[i];
                a_s = s_a[i];
                b_s = s_b[i];
                vld[0] = 1'b1;
                @(negedge clk);
                check($sformatf("stream%0d out_valid", i), 64'(ov[0]), 64'd1);
                check($sformatf("stream%0d result", i), res[0], s_exp[i]);
                check($sformatf("stream%0d err", i), 64'(er[0]), 64'd0);
            end
            vld[0] = 1'b0;
        end

        run_op(0, 3, 64'd200, 64'd7, 64'd0, 64'd28, 1'b0, "div 200/7");
        run_op(0, 4, 64'd200, 64'd7, 64'd0, 64'd4, 1'b0, "rem 200%7");
        run_op(0, 3, 64'h55, 64'd0, 64'd0, 64'hFF, 1'b1, "div by zero");
        run_op(0, 4, 64'h55, 64'd0, 64'd0, 64'h55, 1'b1, "rem by zero");
        run_op(0, 25, 64'h12, 64'h34, 64'h56, 64'd0, 1'b1, "illegal op25");

        // Output held while the consumer stalls, then a queued op goes straight through.
        @(negedge clk);
        out_ready = 1'b0;
        in_op = 5'd2;
        a_s = 64'h10;
        b_s = 64'h11;
        vld[0] = 1'b1;
        @(negedge clk);
        vld[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("hold%0d out_valid", i), 64'(ov[0]), 64'd1);
            check($sformatf("hold%0d result", i), res[0], 64'h10);
            check($sformatf("hold%0d err", i), 64'(er[0]), 64'd0);
            check($sformatf("hold%0d in_ready", i), 64'(rdy[0]), 64'd0);
            a_s = {$urandom, $urandom};
            @(negedge clk);
        end
        out_ready = 1'b1;
        in_op = 5'd13;
        a_s = 64'hA5;
        b_s = 64'h0F;
        vld[0] = 1'b1;
        #1;
        check("b2b in_ready", 64'(rdy[0]), 64'd1);
        @(negedge clk);
        vld[0] = 1'b0;
        check("b2b out_valid", 64'(ov[0]), 64'd1);
        check("b2b result", res[0], 64'hAA);

        run_op(0, 16, 64'h01, 64'd8, 64'd0, 64'h00, 1'b0, "shl by 8");
        run_op(0, 16, 64'h01, 64'd3, 64'd0, 64'h08, 1'b0, "shl by 3");
        run_op(0, 16, 64'h01, 64'h81, 64'd0, 64'h00, 1'b0, "shl by 0x81");
        run_op(0, 15, 64'h80, 64'd7, 64'd0, 64'h01, 1'b0, "shr by 7");
        run_op(0, 17, 64'h00, 64'hAA, 64'h55, 64'h55, 1'b0, "select c");
        run_op(0, 17, 64'h04, 64'hAA, 64'h55, 64'hAA, 1'b0, "select b");
        run_op(0, 20, 64'h07, 64'd0, 64'd0, 64'h01, 1'b0, "xor reduce");
        run_op(0, 22, 64'h01, 64'd0, 64'd0, 64'hFF, 1'b0, "negate");
        run_op(0, 3, 64'hFF, 64'h01, 64'd0, 64'hFF, 1'b0, "div by one");
        run_op(0, 4, 64'h03, 64'hFE, 64'd0, 64'h03, 1'b0, "rem small");

        for (int op = 0; op < 32; op++)
            for (int a = 0; a < 2; a++)
                for (int b = 0; b < 2; b++)
                    for (int c = 0; c < 2; c++)
                        model_op(2, op, 64'(a), 64'(b), 64'(c));

        for (int op = 0; op < 32; op++)
            for (int a = 0; a < 8; a++)
                for (int b = 0; b < 8; b++)
                    model_op(1, op, 64'(a), 64'(b), {$urandom, $urandom});

        for (int i = 0; i < 200; i++) begin
            logic [63:0] rb;
            rb = ($urandom_range(0, 7) == 0) ? 64'd0 : 64'($urandom);
            model_op(0, int'($urandom_range(0, 31)), 64'($urandom), rb, 64'($urandom));
        end

        // Reset during the fourth divider cycle discards the operation.
        @(negedge clk);
        out_ready = 1'b1;
        in_op = 5'd3;
        a_s = 64'd200;
        b_s = 64'd7;
        vld[0] = 1'b1;
        @(negedge clk);
        vld[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("div cycle4 in_ready", 64'(rdy[0]), 64'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid-div reset out_valid", 64'(ov[0]), 64'd0);
        check("mid-div reset in_ready", 64'(rdy[0]), 64'd0);
        rst_n = 1'b1;
        #1;
        check("post-reset in_ready", 64'(rdy[0]), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("post-reset idle%0d out_valid", i), 64'(ov[0]), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_op_unit.md
Name: seq_op_unit

Overview:
- Registered, handshaked, width-parametrised operator unit covering the unsigned Verilog operator set used by our always_comb operator tests, plus reductions and select.
- Single-cycle ops produce a registered result one cycle after accept; div/rem run an iterative restoring divider over WIDTH cycles.
- Valid/ready on both sides with a one-entry output register; sits behind the systest harness as the sequential reference for operator equivalence.

Parameters:
WIDTH, 8, operand/result width; legal range 1..64.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  synchronous, active-low reset.
in_valid  input  1  operands and opcode valid.
in_ready  output  1  unit can accept this cycle.
in_op  input  5  opcode (see Behaviour).
in_a  input  WIDTH  operand a.
in_b  input  WIDTH  operand b.
in_c  input  WIDTH  operand c (qmark only).
out_valid  output  1  result register holds a result.
out_ready  input  1  consumer accepts the result.
out_result  output  WIDTH  result.
out_err  output  1  divide by zero or illegal opcode.

Behaviour:
- Reset when rst_n=0 at a clk edge: state=IDLE, out_valid=0, out_result=0, out_err=0, in_ready=0 during that cycle. Reset mid-division discards the operation with no output.
- States: IDLE (output empty), DIV (iterating), DONE (output held).
- in_ready = (state==IDLE) || (state==DONE && out_ready). It is never high in DIV.
- Accept = in_valid && in_ready.
- Non-div op accepted: next state DONE, out_valid=1 next cycle (latency 1).
- Div/rem accepted with b!=0: next state DIV for exactly WIDTH cycles, then DONE (out_valid at accept+WIDTH+1).
- Divide by zero skips DIV: latency 1. div result = all ones, rem result = a, out_err=1.
- DONE && out_ready && no accept -> IDLE, out_valid=0 next cycle. DONE && out_ready && accept -> back-to-back, no bubble.
- DONE && !out_ready: out_result and out_err stay stable.
- All arithmetic is unsigned. Results are truncated to WIDTH bits. 1-bit results are zero-extended to WIDTH.
- Opcodes:
  - 0 a+b
  - 1 a-b (wraps)
  - 2 a*b (low WIDTH bits)
  - 3 a/b
  - 4 a%b
  - 5 a==b
  - 6 a!=b
  - 7 a<b
  - 8 a<=b
  - 9 a>b
  - 10 a>=b
  - 11 a&b
  - 12 a|b
  - 13 a^b
  - 14 a~^b
  - 15 a>>b
  - 16 a<<b
  - 17 a?b:c (a nonzero selects b)
  - 18 &a
  - 19 |a
  - 20 ^a
  - 21 !a
  - 22 -a
  - 23..31 illegal: result 0, out_err=1, latency 1.
- Shifts with b>=WIDTH yield 0; the full b is compared, not truncated.
- Divider:
  - Operands are latched at accept. Later in_* changes have no effect.
  - One quotient bit per cycle, MSB first. After WIDTH cycles the quotient and remainder are exact.
  - The op latch picks quotient (3) or remainder (4).
- out_err=0 for all legal non-div-zero ops.

Test Plan:
- WIDTH=8, reset, then op0 a=0xF0 b=0x20, out_ready=1 -> out_valid one cycle after accept, result 0x10, err 0; in_ready high every cycle in the stream.
- WIDTH=8, op3 a=200 b=7 -> in_ready low for 8 cycles; out_valid at accept+9, result 28. Repeat with op4 -> result 4.
- WIDTH=8, op3 a=0x55 b=0 -> latency 1, result 0xFF, err 1. op4 -> result 0x55, err 1. op25 -> result 0, err 1.
- WIDTH=8, op2 a=0x10 b=0x11 with out_ready=0 for 3 cycles -> result 0x10 held stable, in_ready=0; out_ready=1 with a new op queued -> back-to-back accept, no idle cycle.
- WIDTH=8, op16 a=0x01 b=8 -> 0x00; op16 b=3 -> 0x08; op17 a=0 b=0xAA c=0x55 -> 0x55; op20 a=0x07 -> 0x01; op22 a=1 -> 0xFF.
- WIDTH=1 and WIDTH=3 sweeps of all opcodes and operands vs a model. Then rst_n=0 during DIV cycle 4 -> out_valid stays 0, state IDLE, in_ready high the cycle after rst_n rises.
